vibrator_scheduler: RTL and testbench
=====================================

Name: vibrator_scheduler

Overview:
- Sequences the vibration motor driver by issuing one-cycle shake_open/shake_close pulses, which the driver's set/reset inputs consume.
- Shares the single motor between NUM_REQ requesters (index 0 highest priority, e.g. alarm, message, keypress), each supplying a burst pattern.
- A pattern is: on time, off time and pulse count, all in milliseconds or counts.
- Sits between application control logic and the motor driver in the clk_50M domain.

Parameters:
- NUM_REQ, 3, number of requesters.
- MS_DIV, 50000, clk_50M cycles per millisecond tick; bench uses 4.
- MS_W, 10, width of on/off time fields in ms.
- CNT_W, 4, width of pulse-count field.

Ports:
- clk_50M  in  1  system clock.
- s_rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  one-cycle request strobe per requester.
- req_on_ms  in  NUM_REQ*MS_W  packed on times; requester i at bits [i*MS_W +: MS_W].
- req_off_ms  in  NUM_REQ*MS_W  packed off times.
- req_count  in  NUM_REQ*CNT_W  packed pulse counts.
- shake_open  out  1  one-cycle pulse: motor on.
- shake_close  out  1  one-cycle pulse: motor off.
- busy  out  1  high while a pattern is active (ON or OFF state).
- grant_id  out  $clog2(NUM_REQ)  index of the active requester; holds its last value when idle.
- done  out  NUM_REQ  one-cycle completion pulse, one-hot.

Behaviour:
- Reset (s_rst high at an edge):
  - State goes to IDLE.
  - pending, shake_open, shake_close, busy, grant_id and done are all cleared.
  - The prescaler and counters are cleared.
  - No shake_close is issued. The driver is reset from the same reset net, so the motor is already off.
  - Reset mid-pattern discards the pattern and all pending requests.
- Request latch:
  - req[i] high at an edge sets pending[i].
  - pending[i] is cleared when i is granted.
  - A new req[i] while i is active sets pending[i] again, so the pattern replays after completion.
  - req[i] in the same cycle pending[i] is cleared by the grant leaves pending[i] set.
- IDLE:
  - If any pending bit is set, grant the lowest set index.
  - On grant, latch that requester's on_ms, off_ms and count.
  - If count==0: pulse done[i] next cycle, issue no shake pulses, stay IDLE.
  - Otherwise: pulse shake_open, load remaining=count, restart the prescaler, go to ON.
  - shake_open appears in the cycle after the edge following the edge that sampled req (2-edge latency).
- ON:
  - Count ms ticks. An on_ms of 0 is treated as 1.
  - After exactly on_ms*MS_DIV cycles from the shake_open pulse: pulse shake_close and decrement remaining.
  - If remaining reaches 0: pulse done[grant_id] in the same cycle as that shake_close, go to IDLE.
  - Otherwise go to OFF.
- OFF:
  - After exactly off_ms*MS_DIV cycles from shake_close (1 cycle if off_ms==0): pulse shake_open, restart the prescaler, go to ON.
- Timing and width rules:
  - The prescaler restarts at every phase entry, so timing is deterministic.
  - The phase counter is MS_W bits. The prescaler is $clog2(MS_DIV) bits.
- Idle between patterns: the next grant is evaluated the cycle after returning to IDLE, so the motor stays off at least 2 cycles between patterns.
- Pulse exclusivity:
  - shake_open and shake_close are never high in the same cycle.
  - No shake pulse is issued in IDLE.
- Config stability: config inputs are sampled only at grant; later changes do not affect the active pattern.

Optional Feature:
- Macro: VIB_PREEMPT_EN.
- Defined: in ON or OFF, a pending index lower than grant_id aborts the active pattern.
  - If in ON, shake_close is pulsed that cycle. No done pulse is issued for the aborted requester, and its pending bit stays clear.
  - The next cycle is IDLE and the winner is granted by normal rules.
- Undefined: no preemption; patterns always run to completion.

Test Plan (MS_DIV=4):
- Single pattern: req[1] with on=2, off=1, count=2 → shake_open 2 cycles after req; shake_close 8 cycles later; shake_open 4 cycles after that; final shake_close 8 cycles later with done[1] in that cycle; busy high throughout.
- Simultaneous: req=3'b110 in one cycle → requester 1 served first, done[1], then requester 2 starts 2 cycles later with grant_id=2.
- Count zero: req[0] with count=0 → done[0] pulse with no shake_open/shake_close; busy stays 0.
- Zero times: on=0, off=0, count=3 → each on phase lasts 4 cycles and each off phase 1 cycle; exactly 3 open and 3 close pulses.
- Reset mid-ON: assert s_rst 3 cycles after shake_open → all outputs 0 next cycle; no shake_close; the pending request queued earlier is lost.
- VIB_PREEMPT_EN: requester 2 active in ON, req[0] → shake_close for the aborted pattern, no done[2], then requester 0's shake_open follows; without the macro, requester 2 completes first.

Source files
------------

// File: rtl/vibrator_scheduler.sv
// vibrator_scheduler
// Shares one vibration motor between NUM_REQ requesters (index 0 wins).
// Each granted pattern is a burst of on/off phases measured in ms ticks.
// The motor driver is steered with one-cycle shake_open/shake_close pulses.
// Optional build macro VIB_PREEMPT_EN: a waiting higher-priority requester
// aborts the active pattern instead of waiting for it to finish.
module vibrator_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int MS_DIV  = 50000,
  parameter int MS_W    = 10,
  parameter int CNT_W   = 4
) (
  input  logic                       clk_50M,
  input  logic                       s_rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*MS_W-1:0]    req_on_ms,
  input  logic [NUM_REQ*MS_W-1:0]    req_off_ms,
  input  logic [NUM_REQ*CNT_W-1:0]   req_count,
  output logic                       shake_open,
  output logic                       shake_close,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         done
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF
  } state_t;

  state_t             state, state_nx;
  logic [NUM_REQ-1:0] pending, pending_nx;
  logic [NUM_REQ-1:0] clr;
  logic [MS_W-1:0]    on_ms_q, on_ms_nx;
  logic [MS_W-1:0]    off_ms_q, off_ms_nx;
  logic [CNT_W-1:0]   remaining, remaining_nx;
  logic [PRE_W-1:0]   prescale, prescale_nx;
  logic [MS_W-1:0]    ms_cnt, ms_cnt_nx;
  logic               cooldown, cooldown_nx;
  logic               open_nx, close_nx;
  logic [NUM_REQ-1:0] done_nx;
  logic [GID_W-1:0]   gid_nx;

  logic [GID_W-1:0]   win;
  logic               found;
  logic [MS_W-1:0]    cfg_on, cfg_off;
  logic [CNT_W-1:0]   cfg_cnt;
  logic               tick;
  logic [MS_W-1:0]    on_last;
  logic               on_end, off_end;
  logic               preempt;

  // Pick the lowest-index pending requester as the grant candidate.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pending[k]) begin
        win   = GID_W'(k);
        found = 1'b1;
      end
    end
  end

`ifdef VIB_PREEMPT_EN
  // Flag a waiting requester that outranks the one currently being served.
  always_comb begin
    preempt = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pending[k] && (GID_W'(k) < grant_id)) begin
        preempt = 1'b1;
      end
    end
  end
`else
  assign preempt = 1'b0;
`endif

  assign cfg_on  = req_on_ms[int'(win)*MS_W +: MS_W];
  assign cfg_off = req_off_ms[int'(win)*MS_W +: MS_W];
  assign cfg_cnt = req_count[int'(win)*CNT_W +: CNT_W];

  // An on time of zero behaves like one millisecond; an off time of zero
  // ends the off phase on its very first cycle.
  assign tick    = (prescale == PRE_LAST);
  assign on_last = (on_ms_q == '0) ? '0 : on_ms_q - 1'b1;
  assign on_end  = tick && (ms_cnt == on_last);
  assign off_end = (off_ms_q == '0) || (tick && (ms_cnt == off_ms_q - 1'b1));

  assign busy = (state != ST_IDLE);

  // Next-state, pattern bookkeeping and registered pulse outputs.
  always_comb begin
    state_nx     = state;
    on_ms_nx     = on_ms_q;
    off_ms_nx    = off_ms_q;
    remaining_nx = remaining;
    prescale_nx  = tick ? '0 : prescale + 1'b1;
    ms_cnt_nx    = tick ? ms_cnt + 1'b1 : ms_cnt;
    cooldown_nx  = 1'b0;
    open_nx      = 1'b0;
    close_nx     = 1'b0;
    done_nx      = '0;
    gid_nx       = grant_id;
    clr          = '0;

    case (state)
      ST_IDLE: begin
        prescale_nx = '0;
        ms_cnt_nx   = '0;
        if (!cooldown && found) begin
          clr[win]  = 1'b1;
          gid_nx    = win;
          on_ms_nx  = cfg_on;
          off_ms_nx = cfg_off;
          if (cfg_cnt == '0) begin
            done_nx[win] = 1'b1;
          end else begin
            open_nx      = 1'b1;
            remaining_nx = cfg_cnt;
            state_nx     = ST_ON;
          end
        end
      end

      ST_ON: begin
        if (preempt) begin
          close_nx    = 1'b1;
          state_nx    = ST_IDLE;
          cooldown_nx = 1'b1;
        end else if (on_end) begin
          close_nx     = 1'b1;
          remaining_nx = remaining - 1'b1;
          prescale_nx  = '0;
          ms_cnt_nx    = '0;
          if (remaining == CNT_W'(1)) begin
            done_nx[grant_id] = 1'b1;
            state_nx          = ST_IDLE;
            cooldown_nx       = 1'b1;
          end else begin
            state_nx = ST_OFF;
          end
        end
      end

      ST_OFF: begin
        if (preempt) begin
          state_nx    = ST_IDLE;
          cooldown_nx = 1'b1;
        end else if (off_end) begin
          open_nx     = 1'b1;
          prescale_nx = '0;
          ms_cnt_nx   = '0;
          state_nx    = ST_ON;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    pending_nx = (pending & ~clr) | req;
  end

  // State and output registers; reset drops any pattern and queued requests.
  always_ff @(posedge clk_50M) begin
    if (s_rst) begin
      state       <= ST_IDLE;
      pending     <= '0;
      on_ms_q     <= '0;
      off_ms_q    <= '0;
      remaining   <= '0;
      prescale    <= '0;
      ms_cnt      <= '0;
      cooldown    <= 1'b0;
      shake_open  <= 1'b0;
      shake_close <= 1'b0;
      done        <= '0;
      grant_id    <= '0;
    end else begin
      state       <= state_nx;
      pending     <= pending_nx;
      on_ms_q     <= on_ms_nx;
      off_ms_q    <= off_ms_nx;
      remaining   <= remaining_nx;
      prescale    <= prescale_nx;
      ms_cnt      <= ms_cnt_nx;
      cooldown    <= cooldown_nx;
      shake_open  <= open_nx;
      shake_close <= close_nx;
      done        <= done_nx;
      grant_id    <= gid_nx;
    end
  end

endmodule

// File: tb/tb_vibrator_scheduler.sv
// tb_vibrator_scheduler
// Drives directed and random requests and compares every output, every
// cycle, against a schedule-based reference model of the motor sequencer.
module tb_vibrator_scheduler;

  localparam int NUM_REQ = 3;
  localparam int MS_DIV  = 4;
  localparam int MS_W    = 10;
  localparam int CNT_W   = 4;
  localparam int MAXC    = 8000;

  logic                     clk_50M = 1'b0;
  logic                     s_rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*MS_W-1:0]  req_on_ms;
  logic [NUM_REQ*MS_W-1:0]  req_off_ms;
  logic [NUM_REQ*CNT_W-1:0] req_count;
  logic                     shake_open;
  logic                     shake_close;
  logic                     busy;
  logic [1:0]               grant_id;
  logic [NUM_REQ-1:0]       done;

  vibrator_scheduler #(
    .NUM_REQ (NUM_REQ),
    .MS_DIV  (MS_DIV),
    .MS_W    (MS_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_50M     (clk_50M),
    .s_rst       (s_rst),
    .req         (req),
    .req_on_ms   (req_on_ms),
    .req_off_ms  (req_off_ms),
    .req_count   (req_count),
    .shake_open  (shake_open),
    .shake_close (shake_close),
    .busy        (busy),
    .grant_id    (grant_id),
    .done        (done)
  );

  always #5 clk_50M = ~clk_50M;

  int errors     = 0;
  int checks     = 0;
  int edge_n     = 0;
  int open_seen  = 0;
  int close_seen = 0;

  // Expected output timeline, indexed by the clock edge after which it shows.
  bit                 exp_open  [MAXC];
  bit                 exp_close [MAXC];
  bit                 exp_busy  [MAXC];
  logic [NUM_REQ-1:0] exp_done  [MAXC];
  logic [NUM_REQ-1:0] m_pending;
  int                 m_free;
  int                 m_gid;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_n, got, want);
    end
  endtask

  // Reference model: on each grant, lay out the whole burst on the timeline.
  task automatic modelEdge();
    logic [NUM_REQ-1:0] clr;
    int w, on_v, off_v, cnt_v, on_c, off_c, t;
    clr = '0;
    if (s_rst) begin
      for (int c = edge_n; c < MAXC; c++) begin
        exp_open[c]  = 1'b0;
        exp_close[c] = 1'b0;
        exp_busy[c]  = 1'b0;
        exp_done[c]  = '0;
      end
      m_pending = '0;
      m_gid     = 0;
      m_free    = edge_n + 1;
    end else begin
      if (edge_n >= m_free && m_pending != '0) begin
        w     = m_pending[0] ? 0 : (m_pending[1] ? 1 : 2);
        on_v  = int'(req_on_ms[w*MS_W +: MS_W]);
        off_v = int'(req_off_ms[w*MS_W +: MS_W]);
        cnt_v = int'(req_count[w*CNT_W +: CNT_W]);
        clr[w] = 1'b1;
        m_gid  = w;
        if (cnt_v == 0) begin
          exp_done[edge_n][w] = 1'b1;
          m_free = edge_n + 1;
        end else begin
          on_c  = ((on_v == 0) ? 1 : on_v) * MS_DIV;
          off_c = (off_v == 0) ? 1 : off_v * MS_DIV;
          t = edge_n;
          for (int k = 0; k < cnt_v; k++) begin
            if (t < MAXC) exp_open[t] = 1'b1;
            t += on_c;
            if (t < MAXC) exp_close[t] = 1'b1;
            if (k < cnt_v - 1) t += off_c;
          end
          if (t < MAXC) exp_done[t][w] = 1'b1;
          for (int c = edge_n; c < t && c < MAXC; c++) exp_busy[c] = 1'b1;
          m_free = t + 2;
        end
      end
      m_pending = (m_pending & ~clr) | req;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk_50M);
    modelEdge();
    #1;
    checkOutput("shake_open", shake_open, exp_open[edge_n]);
    checkOutput("shake_close", shake_close, exp_close[edge_n]);
    checkOutput("busy", busy, exp_busy[edge_n]);
    checkOutput("done", done, exp_done[edge_n]);
    checkOutput("grant_id", grant_id, m_gid);
    checkOutput("pulse_exclusive", shake_open & shake_close, 0);
    if (shake_open === 1'b1) open_seen++;
    if (shake_close === 1'b1) close_seen++;
    edge_n++;
  endtask

  task automatic applyStimulus(input logic rst, input logic [NUM_REQ-1:0] r);
    s_rst = rst;
    req   = r;
    stepCycle();
    s_rst = 1'b0;
    req   = '0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0);
  endtask

  task automatic setCfg(input int idx, input int on_v, input int off_v, input int cnt_v);
    req_on_ms[idx*MS_W +: MS_W]   = MS_W'(on_v);
    req_off_ms[idx*MS_W +: MS_W]  = MS_W'(off_v);
    req_count[idx*CNT_W +: CNT_W] = CNT_W'(cnt_v);
  endtask

  initial begin
    int base_open, base_close;
    logic [NUM_REQ-1:0] r;

    for (int c = 0; c < MAXC; c++) exp_done[c] = '0;
    m_pending  = '0;
    m_free     = 0;
    m_gid      = 0;
    s_rst      = 1'b1;
    req        = '0;
    req_on_ms  = '0;
    req_off_ms = '0;
    req_count  = '0;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, '0);
    idleCycles(2);

    $display("[TB] single pattern on=2 off=1 count=2");
    setCfg(1, 2, 1, 2);
    applyStimulus(1'b0, 3'b010);
    idleCycles(30);

    $display("[TB] simultaneous requests 1 and 2");
    setCfg(1, 1, 1, 1);
    setCfg(2, 2, 0, 2);
    applyStimulus(1'b0, 3'b110);
    idleCycles(40);

    $display("[TB] count zero");
    base_open  = open_seen;
    base_close = close_seen;
    setCfg(0, 1, 1, 0);
    applyStimulus(1'b0, 3'b001);
    idleCycles(6);
    checkOutput("count0_opens", open_seen - base_open, 0);
    checkOutput("count0_closes", close_seen - base_close, 0);

    $display("[TB] zero on/off times");
    base_open  = open_seen;
    base_close = close_seen;
    setCfg(2, 0, 0, 3);
    applyStimulus(1'b0, 3'b100);
    idleCycles(30);
    checkOutput("zero_times_opens", open_seen - base_open, 3);
    checkOutput("zero_times_closes", close_seen - base_close, 3);

    $display("[TB] reset mid-on");
    base_open = open_seen;
    setCfg(2, 3, 1, 2);
    applyStimulus(1'b0, 3'b100);
    setCfg(1, 1, 1, 1);
    applyStimulus(1'b0, 3'b010);
    for (int n = 0; n < 10 && open_seen == base_open; n++) applyStimulus(1'b0, '0);
    checkOutput("open_before_reset", open_seen - base_open, 1);
    idleCycles(2);
    applyStimulus(1'b1, '0);
    base_open  = open_seen;
    base_close = close_seen;
    idleCycles(40);
    checkOutput("after_reset_opens", open_seen - base_open, 0);
    checkOutput("after_reset_closes", close_seen - base_close, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        setCfg(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
      r = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 7) == 0) r[i] = 1'b1;
      end
      applyStimulus(($urandom_range(0, 399) == 0), r);
    end
    idleCycles(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
